// File: rtl/bus_write_arbiter_if.sv
// Request/write bundle for bus_write_arbiter.
// master: arbiter side; slave: requesters plus write transactor.
interface bus_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  localparam int SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic [SW-1:0]         wr_src;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  req_valid,
    input  req_addr,
    input  req_data,
    input  wr_ready,
    output req_ready,
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_src,
    output busy,
    output timeout_err
  );

  modport slave (
    output req_valid,
    output req_addr,
    output req_data,
    output wr_ready,
    input  req_ready,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_src,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/bus_write_arbiter.sv
// Round-robin arbiter funnelling N write requesters
// into one write port, with a wr_ready timeout.
module bus_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  bus_write_arbiter_if.master bus
);
  localparam int SW = $clog2(NUM_REQ);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t        state;
  logic [SW-1:0] last_grant;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] scan;
  logic          gnt_found;
  logic [15:0]   wait_cnt;
  logic          expire;

  // Rotating scan starting just after last_grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = last_grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = (scan == SW'(NUM_REQ - 1)) ? '0 : scan + 1'b1;
      if (!gnt_found && bus.req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan;
      end
    end
  end

  // Grant is combinational so a new write can start
  // the cycle right after a handshake.
  assign bus.req_ready = (state == IDLE && !rst && gnt_found)
                       ? (NUM_REQ'(1) << gnt_idx)
                       : '0;
  assign bus.busy = (state == ISSUE);
  assign expire   = !bus.wr_ready && (wait_cnt >= TMO - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= SW'(NUM_REQ - 1);
      wait_cnt        <= '0;
      bus.wr_valid    <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.wr_src      <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_found) begin
            state        <= ISSUE;
            wait_cnt     <= '0;
            bus.wr_valid <= 1'b1;
            bus.wr_src   <= gnt_idx;
            bus.wr_addr  <= bus.req_addr[int'(gnt_idx)*AW +: AW];
            bus.wr_data  <= bus.req_data[int'(gnt_idx)*DW +: DW];
          end
        end
        ISSUE: begin
          if (bus.wr_ready) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            last_grant   <= bus.wr_src;
            bus.wr_valid <= 1'b0;
          end else if (expire) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            last_grant      <= bus.wr_src;
            bus.wr_valid    <= 1'b0;
            bus.timeout_err <= 1'b1;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_write_arbiter.sv
// Bench for bus_write_arbiter: directed scenarios plus
// random traffic against a cycle-level reference model.
module tb_bus_write_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_write_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

  bus_write_arbiter #(
    .NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [N-1:0]  rv = '0;
  logic [N-1:0]  gnt = '0;
  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];
  logic          wrdy = 1'b1;

  int glog[$];
  int gcyc[$];
  int hs_cnt   = 0;
  int terr_cnt = 0;
  int cyc      = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  bit            mv = 1'b0;
  bit            m_busy, m_terr;
  int            m_src, m_last, m_wait, mg;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  mer;

  task automatic mreset();
    m_busy = 0; m_terr = 0; m_src = 0;
    m_last = N - 1; m_wait = 0;
    m_addr = '0; m_data = '0;
  endtask

  initial forever begin
    @(negedge clk);
    if (!mv) begin
      if (rst) begin
        mreset();
        mv = 1'b1;
      end
    end else begin
      mg  = (rst || m_busy) ? -1 : pick(bus.req_valid, m_last);
      mer = (mg < 0) ? '0 : (N'(1) << mg);
      chk("req_ready", bus.req_ready, mer);
      chk("wr_valid", bus.wr_valid, m_busy);
      chk("busy", bus.busy, m_busy);
      chk("timeout_err", bus.timeout_err, m_terr);
      chk("wr_addr", bus.wr_addr, m_addr);
      chk("wr_data", bus.wr_data, m_data);
      chk("wr_src", bus.wr_src, m_src);
      for (int k = 0; k < N; k++)
        if (bus.req_ready[k]) begin
          glog.push_back(k);
          gcyc.push_back(cyc);
        end
      if (bus.wr_valid && bus.wr_ready) hs_cnt++;
      if (bus.timeout_err) terr_cnt++;
      cyc++;
      m_terr = 0;
      if (rst) begin
        mreset();
      end else if (!m_busy) begin
        if (mg >= 0) begin
          m_busy = 1; m_src = mg; m_wait = 0;
          m_addr = bus.req_addr[mg*AW +: AW];
          m_data = bus.req_data[mg*DW +: DW];
        end
      end else if (bus.wr_ready) begin
        m_busy = 0; m_last = m_src; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait >= TMO) begin
          m_busy = 0; m_terr = 1;
          m_last = m_src; m_wait = 0;
        end
      end
    end
  end

  task automatic drive();
    bus.req_valid = rv;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = ra[i];
      bus.req_data[i*DW +: DW] = rd[i];
    end
    bus.wr_ready = wrdy;
  endtask

  task automatic tick();
    drive();
    #2;
    gnt = bus.req_ready;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    rv &= ~gnt;
  endtask

  task automatic step();
    tick();
    adv();
  endtask

  int s2e[5] = '{0, 1, 2, 3, 0};
  int h0;
  bit stall = 1'b0;

  initial begin
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rd[i] = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    tick();
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_terr", bus.timeout_err, 0);
    chk("rst_addr", bus.wr_addr, 0);
    chk("rst_src", bus.wr_src, 0);
    chk("rst_ready", bus.req_ready, 0);
    adv();

    rst = 1'b0; rv = 4'b0001;
    ra[0] = 32'h10; rd[0] = 32'hAA; wrdy = 1'b1;
    tick();
    chk("s1_ready", bus.req_ready, 4'b0001);
    adv();
    tick();
    chk("s1_wr_valid", bus.wr_valid, 1);
    chk("s1_wr_addr", bus.wr_addr, 32'h10);
    chk("s1_wr_data", bus.wr_data, 32'hAA);
    chk("s1_wr_src", bus.wr_src, 0);
    adv();
    tick();
    chk("s1_busy", bus.busy, 0);
    adv();

    rst = 1'b1;
    step();
    rst = 1'b0;
    glog.delete(); gcyc.delete();
    repeat (10) begin
      for (int i = 0; i < N; i++)
        if (!rv[i]) begin
          ra[i] = $urandom; rd[i] = $urandom;
        end
      rv = 4'hF;
      step();
    end
    chk("s2_count", glog.size(), 5);
    if (glog.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        chk("s2_order", glog[k], s2e[k]);
        if (k > 0)
          chk("s2_gap", gcyc[k] - gcyc[k-1], 2);
      end

    glog.delete(); gcyc.delete();
    rv = 4'b0101;
    ra[0] = $urandom; rd[0] = $urandom;
    ra[2] = $urandom; rd[2] = $urandom;
    repeat (4) step();
    chk("s3_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("s3_first", glog[0], 2);
      chk("s3_second", glog[1], 0);
    end

    rv = 4'b0011; wrdy = 1'b0;
    ra[0] = $urandom; rd[0] = $urandom;
    ra[1] = $urandom; rd[1] = $urandom;
    tick();
    chk("s4_grant", bus.req_ready, 4'b0010);
    adv();
    repeat (TMO) begin
      tick();
      chk("s4_wait_valid", bus.wr_valid, 1);
      chk("s4_wait_terr", bus.timeout_err, 0);
      adv();
    end
    tick();
    chk("s4_terr", bus.timeout_err, 1);
    chk("s4_drop_valid", bus.wr_valid, 0);
    chk("s4_idle", bus.busy, 0);
    chk("s4_next", bus.req_ready, 4'b0001);
    adv();
    wrdy = 1'b1;
    tick();
    chk("s4_terr_clear", bus.timeout_err, 0);
    adv();
    step();

    rv = 4'b0100; wrdy = 1'b0; h0 = hs_cnt;
    ra[2] = 32'h1234_5678; rd[2] = 32'h9ABC_DEF0;
    step();
    ra[2] = 32'hDEAD_BEEF; rd[2] = 32'h0BAD_F00D;
    repeat (3) begin
      tick();
      chk("s5_addr", bus.wr_addr, 32'h1234_5678);
      chk("s5_data", bus.wr_data, 32'h9ABC_DEF0);
      adv();
    end
    wrdy = 1'b1;
    tick();
    chk("s5_hs_valid", bus.wr_valid, 1);
    chk("s5_hs_addr", bus.wr_addr, 32'h1234_5678);
    adv();
    tick();
    chk("s5_busy", bus.busy, 0);
    adv();
    chk("s5_hs_count", hs_cnt - h0, 1);

    rv = 4'b0010; wrdy = 1'b0;
    ra[1] = $urandom; rd[1] = $urandom;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; rv = 4'hF;
    for (int i = 0; i < N; i++) begin
      ra[i] = $urandom; rd[i] = $urandom;
    end
    tick();
    chk("s6_valid", bus.wr_valid, 0);
    chk("s6_busy", bus.busy, 0);
    chk("s6_terr", bus.timeout_err, 0);
    chk("s6_first", bus.req_ready, 4'b0001);
    adv();
    wrdy = 1'b1;
    step();
    rv = '0;
    step();
    step();

    repeat (600) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = $urandom; rd[i] = $urandom;
        end else if (rv[i] && $urandom_range(0, 40) == 0) begin
          rv[i] = 1'b0;
        end
      if ($urandom_range(0, 15) == 0) stall = !stall;
      wrdy = stall ? ($urandom_range(0, 7) == 0)
                   : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; rv = '0; wrdy = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
